// File: rtl/byte_word_packer.sv
// Packs little-endian UART bytes into words and queues them in a small FIFO.
// The byte source stalls only when a word is complete and the FIFO is full.
module byte_word_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int DEPTH          = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_canPeek,
    input  logic [7:0]                        in_peek,
    output logic                              in_consume_en,
    output logic                              out_canPeek,
    output logic [8*BYTES_PER_WORD-1:0]       out_peek,
    input  logic                              out_consume_en,
    output logic [$clog2(BYTES_PER_WORD)-1:0] byte_count,
    output logic [$clog2(DEPTH):0]            word_count
);

    localparam int BCW = $clog2(BYTES_PER_WORD);
    localparam int AW  = $clog2(DEPTH);
    localparam int WW  = 8 * BYTES_PER_WORD;
    localparam logic [BCW-1:0] LAST_BYTE  = BCW'(BYTES_PER_WORD - 1);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    logic [BCW-1:0]                    r_byteCount;
    logic [8*(BYTES_PER_WORD-1)-1:0]   r_asm;
    logic [WW-1:0]                     r_mem [DEPTH];
    logic [AW:0]                       r_wrPtr;
    logic [AW:0]                       r_rdPtr;

    logic        w_lastByte;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [AW:0] w_count;

    // The full test deliberately ignores a same-cycle pop; no bypass path.
    assign w_count       = r_wrPtr - r_rdPtr;
    assign w_lastByte    = (r_byteCount == LAST_BYTE);
    assign w_full        = (w_count == FULL_COUNT);
    assign in_consume_en = reset & in_canPeek & ~(w_lastByte & w_full);
    assign w_push        = in_consume_en & w_lastByte;
    assign w_pop         = out_consume_en & out_canPeek;
    assign out_canPeek   = (w_count != '0);
    assign out_peek      = r_mem[r_rdPtr[AW-1:0]];
    assign byte_count    = r_byteCount;
    assign word_count    = w_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_byteCount <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
        end else begin
            if (in_consume_en) begin
                r_byteCount <= w_lastByte ? '0 : r_byteCount + BCW'(1);
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + (AW + 1)'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + (AW + 1)'(1);
            end
        end
    end

    // Storage is never cleared; the counters alone decide what is valid.
    always_ff @(posedge clock) begin
        if (in_consume_en && !w_lastByte) begin
            for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
                if (r_byteCount == BCW'(k)) begin
                    r_asm[8*k +: 8] <= in_peek;
                end
            end
        end
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= {in_peek, r_asm};
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer with BYTES_PER_WORD=4, DEPTH=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_byte_word_packer;

    logic        clock;
    logic        reset;
    logic        inCanPeek;
    logic [7:0]  inPeek;
    logic        inConsumeEn;
    logic        outCanPeek;
    logic [31:0] outPeek;
    logic        outConsumeEn;
    logic [1:0]  byteCount;
    logic [1:0]  wordCount;

    int nCompared   = 0;
    int nMismatched = 0;

    byte_word_packer #(
        .BYTES_PER_WORD(4),
        .DEPTH(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_canPeek(inCanPeek),
        .in_peek(inPeek),
        .in_consume_en(inConsumeEn),
        .out_canPeek(outCanPeek),
        .out_peek(outPeek),
        .out_consume_en(outConsumeEn),
        .byte_count(byteCount),
        .word_count(wordCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        inCanPeek = 1'b1;
        inPeek    = b;
        tick();
        inCanPeek = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; inCanPeek = 1'b1; inPeek = 8'h5A; outConsumeEn = 1'b0;
        #1;
        nCompared++;
        if (inConsumeEn !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_consume: got %b expected 0", inConsumeEn); end
        tick();
        tick();
        nCompared++;
        if (byteCount !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_byte_count: got %0d expected 0", byteCount); end
        nCompared++;
        if (wordCount !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_word_count: got %0d expected 0", wordCount); end
        nCompared++;
        if (outCanPeek !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_can_peek: got %b expected 0", outCanPeek); end
        inCanPeek = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        logic [7:0] bytesIn [4];
        bytesIn = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            inCanPeek = 1'b1; inPeek = bytesIn[i];
            #1;
            nCompared++;
            if (inConsumeEn !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_accept%0d: got %b expected 1", i, inConsumeEn); end
            tick();
        end
        inCanPeek = 1'b0;
        nCompared++;
        if (outCanPeek !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_can_peek: got %b expected 1", outCanPeek); end
        nCompared++;
        if (outPeek !== 32'h44332211) begin nMismatched++; $display("[TB] FAIL single_peek: got %h expected 44332211", outPeek); end
        nCompared++;
        if (wordCount !== 2'd1) begin nMismatched++; $display("[TB] FAIL single_word_count: got %0d expected 1", wordCount); end
        nCompared++;
        if (byteCount !== 2'd0) begin nMismatched++; $display("[TB] FAIL single_byte_count: got %0d expected 0", byteCount); end
        outConsumeEn = 1'b1;
        tick();
        outConsumeEn = 1'b0;
        nCompared++;
        if (wordCount !== 2'd0) begin nMismatched++; $display("[TB] FAIL single_drain: got %0d expected 0", wordCount); end
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 11; i++) begin
            inCanPeek = 1'b1; inPeek = 8'(i);
            #1;
            nCompared++;
            if (inConsumeEn !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_accept%0d: got %b expected 1", i, inConsumeEn); end
            tick();
        end
        nCompared++;
        if (wordCount !== 2'd2) begin nMismatched++; $display("[TB] FAIL stall_word_count: got %0d expected 2", wordCount); end
        nCompared++;
        if (byteCount !== 2'd3) begin nMismatched++; $display("[TB] FAIL stall_byte_count: got %0d expected 3", byteCount); end
        inCanPeek = 1'b1; inPeek = 8'h0B;
        #1;
        nCompared++;
        if (inConsumeEn !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_blocked: got %b expected 0", inConsumeEn); end
        tick();
        nCompared++;
        if (byteCount !== 2'd3) begin nMismatched++; $display("[TB] FAIL stall_held: got %0d expected 3", byteCount); end
        nCompared++;
        if (outPeek !== 32'h03020100) begin nMismatched++; $display("[TB] FAIL stall_head0: got %h expected 03020100", outPeek); end
        outConsumeEn = 1'b1;
        #1;
        nCompared++;
        if (inConsumeEn !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_no_bypass: got %b expected 0", inConsumeEn); end
        tick();
        outConsumeEn = 1'b0;
        nCompared++;
        if (inConsumeEn !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_release: got %b expected 1", inConsumeEn); end
        nCompared++;
        if (outPeek !== 32'h07060504) begin nMismatched++; $display("[TB] FAIL stall_head1: got %h expected 07060504", outPeek); end
        tick();
        inCanPeek = 1'b0;
        nCompared++;
        if (wordCount !== 2'd2) begin nMismatched++; $display("[TB] FAIL stall_refill: got %0d expected 2", wordCount); end
        nCompared++;
        if (byteCount !== 2'd0) begin nMismatched++; $display("[TB] FAIL stall_wrap: got %0d expected 0", byteCount); end
        outConsumeEn = 1'b1;
        tick();
        nCompared++;
        if (outPeek !== 32'h0B0A0908) begin nMismatched++; $display("[TB] FAIL stall_head2: got %h expected 0B0A0908", outPeek); end
        tick();
        outConsumeEn = 1'b0;
        nCompared++;
        if (outCanPeek !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_empty: got %b expected 0", outCanPeek); end
    endtask

    task automatic test_streaming();
        logic [31:0] expWords [4];
        logic [1:0]  expCount;
        expWords = '{32'h43424140, 32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C};
        outConsumeEn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            inCanPeek = 1'b1; inPeek = 8'(8'h40 + i);
            #1;
            nCompared++;
            if (inConsumeEn !== 1'b1) begin nMismatched++; $display("[TB] FAIL stream_accept%0d: got %b expected 1", i, inConsumeEn); end
            tick();
            expCount = ((i % 4) == 3) ? 2'd1 : 2'd0;
            nCompared++;
            if (wordCount !== expCount) begin nMismatched++; $display("[TB] FAIL stream_count%0d: got %0d expected %0d", i, wordCount, expCount); end
            if ((i % 4) == 3) begin
                nCompared++;
                if (outPeek !== expWords[i/4]) begin nMismatched++; $display("[TB] FAIL stream_word%0d: got %h expected %h", i/4, outPeek, expWords[i/4]); end
            end
        end
        inCanPeek = 1'b0;
        tick();
        outConsumeEn = 1'b0;
        nCompared++;
        if (wordCount !== 2'd0) begin nMismatched++; $display("[TB] FAIL stream_drain: got %0d expected 0", wordCount); end
    endtask

    task automatic test_back_to_back();
        sendByte(8'hC0); sendByte(8'hC1); sendByte(8'hC2); sendByte(8'hC3);
        sendByte(8'hD0); sendByte(8'hD1); sendByte(8'hD2);
        nCompared++;
        if (wordCount !== 2'd1) begin nMismatched++; $display("[TB] FAIL b2b_pre_count: got %0d expected 1", wordCount); end
        nCompared++;
        if (outPeek !== 32'hC3C2C1C0) begin nMismatched++; $display("[TB] FAIL b2b_pre_peek: got %h expected C3C2C1C0", outPeek); end
        outConsumeEn = 1'b1;
        sendByte(8'hD3);
        outConsumeEn = 1'b0;
        nCompared++;
        if (wordCount !== 2'd1) begin nMismatched++; $display("[TB] FAIL b2b_count: got %0d expected 1", wordCount); end
        nCompared++;
        if (outPeek !== 32'hD3D2D1D0) begin nMismatched++; $display("[TB] FAIL b2b_peek: got %h expected D3D2D1D0", outPeek); end
        outConsumeEn = 1'b1;
        tick();
        outConsumeEn = 1'b0;
        nCompared++;
        if (wordCount !== 2'd0) begin nMismatched++; $display("[TB] FAIL b2b_drain: got %0d expected 0", wordCount); end
    endtask

    task automatic test_reset_mid_word();
        sendByte(8'hAA); sendByte(8'hBB);
        nCompared++;
        if (byteCount !== 2'd2) begin nMismatched++; $display("[TB] FAIL midrst_partial: got %0d expected 2", byteCount); end
        reset = 1'b0; inCanPeek = 1'b1; inPeek = 8'hCC;
        #1;
        nCompared++;
        if (inConsumeEn !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_consume: got %b expected 0", inConsumeEn); end
        tick();
        reset = 1'b1; inCanPeek = 1'b0;
        nCompared++;
        if (byteCount !== 2'd0) begin nMismatched++; $display("[TB] FAIL midrst_byte_count: got %0d expected 0", byteCount); end
        nCompared++;
        if (outCanPeek !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_can_peek: got %b expected 0", outCanPeek); end
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
        nCompared++;
        if (outPeek !== 32'h04030201) begin nMismatched++; $display("[TB] FAIL midrst_word: got %h expected 04030201", outPeek); end
        nCompared++;
        if (wordCount !== 2'd1) begin nMismatched++; $display("[TB] FAIL midrst_count: got %0d expected 1", wordCount); end
        outConsumeEn = 1'b1;
        tick();
        outConsumeEn = 1'b0;
    endtask

    task automatic test_empty_consume();
        outConsumeEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nCompared++;
            if (wordCount !== 2'd0) begin nMismatched++; $display("[TB] FAIL empty_pop%0d: got %0d expected 0", i, wordCount); end
        end
        outConsumeEn = 1'b0;
        sendByte(8'h5A); sendByte(8'h6B); sendByte(8'h7C); sendByte(8'h8D);
        nCompared++;
        if (wordCount !== 2'd1) begin nMismatched++; $display("[TB] FAIL empty_count: got %0d expected 1", wordCount); end
        nCompared++;
        if (outPeek !== 32'h8D7C6B5A) begin nMismatched++; $display("[TB] FAIL empty_word: got %h expected 8D7C6B5A", outPeek); end
        sendByte(8'h10); sendByte(8'h11); sendByte(8'h12); sendByte(8'h13);
        nCompared++;
        if (wordCount !== 2'd2) begin nMismatched++; $display("[TB] FAIL empty_count2: got %0d expected 2", wordCount); end
        outConsumeEn = 1'b1;
        tick();
        nCompared++;
        if (outPeek !== 32'h13121110) begin nMismatched++; $display("[TB] FAIL empty_second: got %h expected 13121110", outPeek); end
        tick();
        outConsumeEn = 1'b0;
        nCompared++;
        if (wordCount !== 2'd0) begin nMismatched++; $display("[TB] FAIL empty_final: got %0d expected 0", wordCount); end
    endtask

    initial begin
        reset = 1'b0; inCanPeek = 1'b0; inPeek = 8'h00; outConsumeEn = 1'b0;
        test_reset();
        test_single_word();
        test_full_stall();
        test_streaming();
        test_back_to_back();
        test_reset_mid_word();
        test_empty_consume();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
